// File: rtl/button_cmd_scheduler_pkg.sv
// Shared types, default sizes and the round-robin winner function for button_cmd_scheduler.
// Hold-off support is selected in the top by BUTTON_CMD_SCHEDULER_HOLDOFF_EN.
package button_cmd_scheduler_pkg;

    localparam int DEF_N_REQ          = 4;
    localparam int DEF_HOLDOFF_CYCLES = 16;
    localparam int MAX_N_REQ          = 8;

    // Encoding is identical whether or not the hold-off state is built.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // First set bit found scanning upward from (last+1) mod n, wrapping.
    // The scan runs downward in offset so the closest candidate is written last.
    function automatic int rr_winner(input logic [MAX_N_REQ-1:0] pend,
                                     input int                   last,
                                     input int                   n);
        logic [2:0] idx;
        int         win;
        win = 0;
        for (int i = n; i >= 1; i--) begin
            idx = 3'((last + i) % n);
            if (pend[idx]) begin
                win = int'(idx);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/button_cmd_scheduler_rr_pick.sv
// Combinational round-robin priority encoder: picks the next pending requester
// after the last granted one.
module rr_pick
    import button_cmd_scheduler_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_pending,
    input  logic [ID_W-1:0]  i_last_grant,
    output logic [ID_W-1:0]  o_winner,
    output logic             o_any
);

    logic [MAX_N_REQ-1:0] w_pend;

    always_comb begin
        w_pend             = '0;
        w_pend[N_REQ-1:0]  = i_pending;
    end

    assign o_winner = ID_W'(rr_winner(w_pend, int'(i_last_grant), N_REQ));
    assign o_any    = |i_pending;

endmodule

// File: rtl/button_cmd_scheduler.sv
// Latches button request pulses and issues them one at a time, round-robin, to a shared target.
// BUTTON_CMD_SCHEDULER_HOLDOFF_EN adds a HOLDOFF_CYCLES idle gap after each completed command.
module button_cmd_scheduler
    import button_cmd_scheduler_pkg::*;
#(
    parameter int N_REQ          = DEF_N_REQ,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    localparam int ID_W          = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             cmd_ready,
    output logic             cmd_start,
    output logic [ID_W-1:0]  cmd_id,
    output logic [N_REQ-1:0] pending,
    output logic             busy,
    output logic             dropped,
    output logic [1:0]       dbg_state
);

    // Handshake: cmd_start is a one-cycle strobe raised only after an IDLE cycle that
    // saw pending work and cmd_ready=1; the command counts as finished on the first
    // WAIT cycle (never the ISSUE cycle) that sees cmd_ready=1 again.

    state_e           r_state;
    state_e           w_state_nx;
    logic [N_REQ-1:0] r_pending;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_pending_nx;
    logic             r_cmd_start;
    logic             r_busy;
    logic             r_dropped;
    logic [ID_W-1:0]  r_cmd_id;
    logic [ID_W-1:0]  r_last_grant;
    logic [ID_W-1:0]  w_winner;
    logic             w_any;
    logic             w_grant;
    logic             w_drop;
`ifdef BUTTON_CMD_SCHEDULER_HOLDOFF_EN
    localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES - 1);
    logic [15:0]      r_hold_cnt;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .i_pending    (r_pending),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any        (w_any)
    );

    always_comb begin
        w_clr = '0;
        if (r_state == ST_ISSUE) begin
            w_clr[r_cmd_id] = 1'b1;
        end
    end

    // A new pulse on the bit being granted re-arms it rather than counting as a drop.
    assign w_pending_nx = (r_pending & ~w_clr) | req_pulse;
    assign w_drop       = |(req_pulse & r_pending & ~w_clr);
    assign w_grant      = (r_state == ST_IDLE) && w_any && cmd_ready;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nx = ST_WAIT;
            ST_WAIT: begin
                if (cmd_ready) begin
`ifdef BUTTON_CMD_SCHEDULER_HOLDOFF_EN
                    w_state_nx = ST_HOLD;
`else
                    w_state_nx = ST_IDLE;
`endif
                end
            end
`ifdef BUTTON_CMD_SCHEDULER_HOLDOFF_EN
            ST_HOLD: begin
                if (r_hold_cnt == 16'd0) begin
                    w_state_nx = ST_IDLE;
                end
            end
`endif
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_cmd_start  <= 1'b0;
            r_cmd_id     <= '0;
            r_busy       <= 1'b0;
            r_dropped    <= 1'b0;
            r_last_grant <= ID_W'(N_REQ - 1);
        end else begin
            r_state     <= w_state_nx;
            r_pending   <= w_pending_nx;
            r_cmd_start <= (w_state_nx == ST_ISSUE);
            r_busy      <= (w_state_nx != ST_IDLE);
            r_dropped   <= w_drop;
            if (w_grant) begin
                r_cmd_id <= w_winner;
            end
            if (r_state == ST_ISSUE) begin
                r_last_grant <= r_cmd_id;
            end
        end
    end

`ifdef BUTTON_CMD_SCHEDULER_HOLDOFF_EN
    // Loaded as the FSM leaves WAIT, so HOLD lasts exactly HOLDOFF_CYCLES clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= 16'd0;
        end else if ((r_state == ST_WAIT) && cmd_ready) begin
            r_hold_cnt <= HOLD_LOAD;
        end else if ((r_state == ST_HOLD) && (r_hold_cnt != 16'd0)) begin
            r_hold_cnt <= r_hold_cnt - 16'd1;
        end
    end
`endif

    assign cmd_start = r_cmd_start;
    assign cmd_id    = r_cmd_id;
    assign pending   = r_pending;
    assign busy      = r_busy;
    assign dropped   = r_dropped;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Directed bench for button_cmd_scheduler (N_REQ=4, HOLDOFF_CYCLES=16); works with or
// without BUTTON_CMD_SCHEDULER_HOLDOFF_EN defined.
`timescale 1ns/1ps
module tb_button_cmd_scheduler;
    import button_cmd_scheduler_pkg::*;

    localparam int N    = 4;
    localparam int HOLD = 16;
`ifdef BUTTON_CMD_SCHEDULER_HOLDOFF_EN
    localparam int HOLD_EXP = HOLD;
`else
    localparam int HOLD_EXP = 0;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic [N-1:0] req_pulse = '0;
    logic         cmd_ready = 1'b0;
    logic         cmd_start;
    logic [1:0]   cmd_id;
    logic [N-1:0] pending;
    logic         busy;
    logic         dropped;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int drop_cnt = 0;
    int g_id[$];
    int g_cyc[$];
    logic prev_start = 1'b0;

    button_cmd_scheduler #(
        .N_REQ          (N),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_pulse (req_pulse),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_id    (cmd_id),
        .pending   (pending),
        .busy      (busy),
        .dropped   (dropped),
        .dbg_state (dbg_state)
    );

    // Clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // Grant log and strobe shape monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (dropped) drop_cnt++;
            if (cmd_start) begin
                g_id.push_back(int'(cmd_id));
                g_cyc.push_back(cyc);
                total++;
                if (prev_start || (dbg_state !== ST_ISSUE)) begin
                    bad++;
                    $display("FAIL start_strobe: prev_start=%0b state=%0d, required single cycle in ISSUE",
                             prev_start, dbg_state);
                end
            end
            prev_start = cmd_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic run_target(input int ncycles, input int lat);
        int cnt;
        cnt = 0;
        for (int k = 0; k < ncycles; k++) begin
            step();
            if (cmd_start) begin
                cnt = 0;
                if (lat > 0) cmd_ready = 1'b0;
            end else if (!cmd_ready) begin
                cnt++;
                if (cnt >= lat) cmd_ready = 1'b1;
            end
        end
        cmd_ready = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || (pending != '0)) && (n < 300)) begin
            step();
            n++;
        end
        total++;
        if (busy || (pending != '0)) begin
            bad++;
            $display("FAIL %s_idle: busy=%0b pending=%b after %0d cycles, required 0/0000", name, busy, pending, n);
        end
    endtask

    // Tests
    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({cmd_start, cmd_id, pending, busy, dropped, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset_async: start=%b id=%0d pend=%b busy=%b drop=%b st=%0d, required all 0",
                     cmd_start, cmd_id, pending, busy, dropped, dbg_state);
        end
        cmd_ready = 1'b1;
        req_pulse = 4'b1111;
        step();
        step();
        total++;
        if ({cmd_start, cmd_id, pending, busy, dropped, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset_held: start=%b id=%0d pend=%b busy=%b drop=%b st=%0d, required all 0",
                     cmd_start, cmd_id, pending, busy, dropped, dbg_state);
        end
        req_pulse = '0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int t0;
        g_id.delete();
        g_cyc.delete();
        cmd_ready = 1'b1;
        req_pulse = 4'b0001;
        t0 = cyc;
        step();
        req_pulse = '0;
        total++;
        if ({cmd_start, pending} !== {1'b0, 4'b0001}) begin
            bad++;
            $display("FAIL single_latch: start=%b pending=%b, required 0 0001", cmd_start, pending);
        end
        step();
        total++;
        if ({cmd_start, cmd_id, busy} !== {1'b1, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL single_issue: start=%b id=%0d busy=%b, required 1 0 1", cmd_start, cmd_id, busy);
        end
        step();
        total++;
        if ({cmd_start, pending, dbg_state} !== {1'b0, 4'b0000, ST_WAIT}) begin
            bad++;
            $display("FAIL single_clear: start=%b pending=%b st=%0d, required 0 0000 2", cmd_start, pending, dbg_state);
        end
        wait_idle("single");
        total++;
        if ((g_cyc.size() != 1) || (g_cyc[0] != t0 + 2)) begin
            bad++;
            $display("FAIL single_latency: grants=%0d start_cycle_offset=%0d, required 1 grant at offset 2",
                     g_cyc.size(), (g_cyc.size() > 0) ? g_cyc[0] - t0 : -1);
        end
    endtask

    task automatic test_round_robin();
        int exp_ids[3];
        exp_ids = '{0, 1, 3};
        do_reset();
        cmd_ready = 1'b1;
        g_id.delete();
        g_cyc.delete();
        req_pulse = 4'b1011;
        step();
        req_pulse = '0;
        run_target(100, 3);
        total++;
        if (g_id.size() != 3) begin
            bad++;
            $display("FAIL rr_count: got %0d grants, required 3", g_id.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (g_id[i] != exp_ids[i]) begin
                    bad++;
                    $display("FAIL rr_order[%0d]: got id %0d, required %0d", i, g_id[i], exp_ids[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                total++;
                if (g_cyc[i] - g_cyc[i-1] != 5 + HOLD_EXP) begin
                    bad++;
                    $display("FAIL rr_gap[%0d]: got %0d cycles, required %0d", i, g_cyc[i] - g_cyc[i-1], 5 + HOLD_EXP);
                end
            end
        end
        wait_idle("rr");
    endtask

    task automatic test_drop();
        cmd_ready = 1'b0;
        drop_cnt = 0;
        req_pulse = 4'b0100;
        step();
        req_pulse = '0;
        total++;
        if ({pending, dropped} !== {4'b0100, 1'b0}) begin
            bad++;
            $display("FAIL drop_first: pending=%b dropped=%b, required 0100 0", pending, dropped);
        end
        for (int k = 0; k < 2; k++) begin
            req_pulse = 4'b0100;
            step();
            req_pulse = '0;
            total++;
            if (dropped !== 1'b1) begin
                bad++;
                $display("FAIL drop_pulse[%0d]: dropped=%b, required 1", k, dropped);
            end
            step();
            total++;
            if (dropped !== 1'b0) begin
                bad++;
                $display("FAIL drop_clear[%0d]: dropped=%b, required 0", k, dropped);
            end
        end
        total++;
        if (drop_cnt != 2) begin
            bad++;
            $display("FAIL drop_count: got %0d dropped cycles, required 2", drop_cnt);
        end
        g_id.delete();
        g_cyc.delete();
        cmd_ready = 1'b1;
        wait_idle("drop");
        total++;
        if ((g_id.size() != 1) || (g_id[0] != 2)) begin
            bad++;
            $display("FAIL drop_grant: got %0d grants first id %0d, required 1 grant id 2",
                     g_id.size(), (g_id.size() > 0) ? g_id[0] : -1);
        end
    endtask

    task automatic test_set_wins();
        cmd_ready = 1'b1;
        drop_cnt = 0;
        g_id.delete();
        g_cyc.delete();
        req_pulse = 4'b0010;
        step();
        req_pulse = '0;
        step();
        total++;
        if ({cmd_start, cmd_id} !== {1'b1, 2'd1}) begin
            bad++;
            $display("FAIL setwin_issue: start=%b id=%0d, required 1 1", cmd_start, cmd_id);
        end
        req_pulse = 4'b0010;
        step();
        req_pulse = '0;
        total++;
        if ({pending, dropped} !== {4'b0010, 1'b0}) begin
            bad++;
            $display("FAIL setwin_keep: pending=%b dropped=%b, required 0010 0", pending, dropped);
        end
        wait_idle("setwin");
        total++;
        if ((g_id.size() != 2) || (g_id[0] != 1) || (g_id[1] != 1) || (drop_cnt != 0)) begin
            bad++;
            $display("FAIL setwin_grants: got %0d grants drops=%0d, required 2 grants of id 1 and 0 drops",
                     g_id.size(), drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        cmd_ready = 1'b1;
        req_pulse = 4'b0010;
        step();
        req_pulse = '0;
        step();
        cmd_ready = 1'b0;
        req_pulse = 4'b0100;
        step();
        req_pulse = '0;
        total++;
        if ({dbg_state, pending} !== {ST_WAIT, 4'b0100}) begin
            bad++;
            $display("FAIL rstmid_setup: st=%0d pending=%b, required 2 0100", dbg_state, pending);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({cmd_start, cmd_id, pending, busy, dropped, dbg_state} !== '0) begin
            bad++;
            $display("FAIL rstmid_async: start=%b id=%0d pend=%b busy=%b drop=%b st=%0d, required all 0",
                     cmd_start, cmd_id, pending, busy, dropped, dbg_state);
        end
        step();
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        g_id.delete();
        g_cyc.delete();
        for (int k = 0; k < 10; k++) step();
        total++;
        if ((g_id.size() != 0) || busy || (pending != '0)) begin
            bad++;
            $display("FAIL rstmid_quiet: grants=%0d busy=%b pending=%b, required 0 0 0000", g_id.size(), busy, pending);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        do_reset();
        cmd_ready = 1'b1;
        g_id.delete();
        g_cyc.delete();
        req_pulse = 4'b0001;
        t0 = cyc;
        step();
        req_pulse = 4'b0010;
        step();
        req_pulse = '0;
        wait_idle("b2b");
        total++;
        if ((g_id.size() != 2) || (g_id[0] != 0) || (g_id[1] != 1)) begin
            bad++;
            $display("FAIL b2b_ids: got %0d grants, required ids 0 then 1", g_id.size());
        end else begin
            total++;
            if (g_cyc[0] != t0 + 2) begin
                bad++;
                $display("FAIL b2b_latency: got offset %0d, required 2", g_cyc[0] - t0);
            end
            total++;
            if (g_cyc[1] - g_cyc[0] != 3 + HOLD_EXP) begin
                bad++;
                $display("FAIL b2b_gap: got %0d cycles, required %0d", g_cyc[1] - g_cyc[0], 3 + HOLD_EXP);
            end
        end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_set_wins();
        test_reset_mid();
        test_back_to_back();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_cmd_scheduler.md
BUTTON_CMD_SCHEDULER -- requirements
Module: button_cmd_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter HOLDOFF_CYCLES, default 16: idle clocks after each completed command, range 1..65535.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_pulse  input  N_REQ  single-cycle request pulses from upstream one-shot generators; bit i is requester i.
REQ-006 cmd_ready  input  1  shared command target idle and able to accept cmd_start.
REQ-007 cmd_start  output  1  registered single-cycle start strobe to the target.
REQ-008 cmd_id  output  clog2(N_REQ)  registered index of the granted requester; valid and stable from cmd_start through return to ST_IDLE.
REQ-009 pending  output  N_REQ  registered latched-request vector.
REQ-010 busy  output  1  registered; high in every state except ST_IDLE.
REQ-011 dropped  output  1  registered single-cycle pulse when a request hits an already-pending bit.

Function
REQ-012 req_pulse[i]=1 SHALL set pending[i] on the next edge.
REQ-013 A request on a bit that is already pending SHALL leave it pending, drop the request, and pulse dropped the next cycle.
REQ-014 A set and a grant-clear of the same pending bit in the same cycle SHALL leave the bit set (set wins), with no dropped pulse.
REQ-015 FSM states: ST_IDLE, ST_ISSUE, ST_WAIT, ST_HOLD.
REQ-016 ST_IDLE -> ST_ISSUE when pending is non-zero and cmd_ready=1; winner chosen round-robin and registered into cmd_id at that edge.
REQ-017 Round-robin: search starts at (last_grant+1) mod N_REQ; last_grant resets to N_REQ-1, so index 0 has highest priority after reset.
REQ-018 ST_ISSUE lasts exactly one cycle: cmd_start=1, pending[cmd_id] cleared, last_grant updated, then -> ST_WAIT.
REQ-019 ST_WAIT: minimum one cycle; exits when cmd_ready=1 to ST_HOLD (or ST_IDLE per REQ-028).
REQ-020 ST_HOLD: counter loads HOLDOFF_CYCLES-1 on entry, decrements each cycle, -> ST_IDLE on zero; no grant issued during ST_HOLD.
REQ-021 Latency: pulse at cycle t with FSM in ST_IDLE and cmd_ready=1 -> cmd_start high in cycle t+2.
REQ-022 cmd_start SHALL never be high in consecutive cycles or outside ST_ISSUE.
REQ-023 Requests arriving in any state SHALL be latched; none lost except per REQ-013.

Reset
REQ-024 rst_n=0 SHALL immediately force ST_IDLE, pending=0, cmd_start=0, cmd_id=0, busy=0, dropped=0, hold counter=0, last_grant=N_REQ-1.
REQ-025 Reset asserted mid-command SHALL abandon the command; no cmd_start after release until a new request.
REQ-026 Reset deassertion is synchronised externally; the block needs no internal synchroniser.

Configuration
REQ-027 Macro BUTTON_CMD_SCHEDULER_HOLDOFF_EN defined: ST_HOLD and its counter present per REQ-020.
REQ-028 Macro undefined: no ST_HOLD and no counter; ST_WAIT exits directly to ST_IDLE; HOLDOFF_CYCLES ignored; state encoding unchanged.

Structure
REQ-029 Package button_cmd_scheduler_pkg SHALL hold the state enum typedef, default N_REQ and HOLDOFF_CYCLES constants, and a round-robin winner function.
REQ-030 One sub-module, rr_pick (combinational round-robin priority encoder: pending, last_grant -> winner, any), is natural; FSM, pending register and counter stay in the top.

Verification (macro defined, N_REQ=4, HOLDOFF_CYCLES=16 unless stated)
REQ-031 req_pulse=0001 at t, cmd_ready=1 -> pending=0001 at t+1, cmd_start=1 and cmd_id=0 at t+2, pending=0000 at t+3.
REQ-032 req_pulse=1011 in one cycle, target ready 3 cycles after each start -> grants in order 0,1,3; each cmd_start separated by 1+3+16 cycles plus idle/issue.
REQ-033 req_pulse[2] pulsed twice while pending[2]=1 -> two dropped pulses; exactly one grant with cmd_id=2.
REQ-034 req_pulse[1] in the ST_ISSUE cycle granting id 1 -> pending[1] remains 1; a second grant with cmd_id=1 follows; dropped stays 0.
REQ-035 rst_n low for 1 cycle during ST_WAIT with pending=0100 -> all outputs 0 immediately, FSM ST_IDLE, no cmd_start for 10 cycles after release.
REQ-036 Macro undefined: back-to-back requests 0 then 1 with cmd_ready held 1 -> second cmd_start exactly 3 cycles after the first (ISSUE, WAIT, IDLE).
